// File: rtl/fb_write_scheduler.sv
// Frame-buffer write-port scheduler: forwards a pixel stream to sequential
// addresses and, on request, fills the whole frame with a single colour.
module fb_write_scheduler #(
  parameter int unsigned ADDR_W   = 18,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned FB_DEPTH = 76800
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              px_valid,
  input  logic [DATA_W-1:0] px_data,
  output logic              px_ready,
  input  logic              frame_start,
  input  logic              clear_req,
  input  logic [DATA_W-1:0] clear_color,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              clear_busy,
  output logic              frame_done
);

  typedef enum logic [0:0] {
    ST_STREAM = 1'b0,
    ST_CLEAR  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  state_t              state;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [DATA_W-1:0]   clr_color;
  logic                handshake;
  logic [ADDR_W-1:0]   wr_ptr_next;

  // Source may only push while streaming; the fill owns the write port otherwise.
  assign px_ready    = (state == ST_STREAM);
  assign handshake   = px_valid & px_ready;
  assign wr_ptr_next = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_STREAM;
      wr_ptr     <= '0;
      clr_ptr    <= '0;
      clr_color  <= '0;
      bram_wea   <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
      frame_done <= 1'b0;
      clear_busy <= 1'b0;
    end else begin
      bram_wea   <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        ST_STREAM: begin
          if (handshake) begin
            bram_wea   <= 1'b1;
            bram_addr  <= wr_ptr;
            bram_din   <= px_data;
            frame_done <= (wr_ptr == LAST_ADDR);
            // A coincident frame_start still lets this pixel land at the old pointer.
            wr_ptr     <= frame_start ? '0 : wr_ptr_next;
          end else if (frame_start) begin
            wr_ptr <= '0;
          end
          if (clear_req) begin
            clr_color  <= clear_color;
            clr_ptr    <= '0;
            state      <= ST_CLEAR;
            clear_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          bram_wea   <= 1'b1;
          bram_addr  <= clr_ptr;
          bram_din   <= clr_color;
          frame_done <= (clr_ptr == LAST_ADDR);
          if (clr_ptr == LAST_ADDR) begin
            state      <= ST_STREAM;
            clear_busy <= 1'b0;
            wr_ptr     <= '0;
          end else begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
          end
        end
        default: begin
          state      <= ST_STREAM;
          clear_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Self-checking bench for fb_write_scheduler with an 8-pixel frame.
module tb_fb_write_scheduler;
  localparam int AW    = 4;
  localparam int DW    = 12;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          px_valid = 1'b0;
  logic [DW-1:0] px_data = '0;
  logic          px_ready;
  logic          frame_start = 1'b0;
  logic          clear_req = 1'b0;
  logic [DW-1:0] clear_color = '0;
  logic          bram_wea;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic          clear_busy;
  logic          frame_done;

  fb_write_scheduler #(.ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
    .frame_start(frame_start), .clear_req(clear_req), .clear_color(clear_color),
    .bram_wea(bram_wea), .bram_addr(bram_addr), .bram_din(bram_din),
    .clear_busy(clear_busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic last_hs;

  // Reference model: pointer arithmetic done with plain integers and modulo.
  bit m_clearing;
  int m_wr, m_next_fill, m_color;
  int e_wea, e_addr, e_din, e_fd;

  typedef struct {
    logic rst_n, v; logic [DW-1:0] d; logic fs, cr; logic [DW-1:0] cc;
    int ewea, eaddr, edin, efd, ebusy, erdy;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic v, int d, logic fs, logic cr, int cc,
                              int ewea, int eaddr, int edin, int efd, int ebusy, int erdy);
    vec_t t;
    t.rst_n = r; t.v = v; t.d = DW'(d); t.fs = fs; t.cr = cr; t.cc = DW'(cc);
    t.ewea = ewea; t.eaddr = eaddr; t.edin = edin; t.efd = efd; t.ebusy = ebusy; t.erdy = erdy;
    return t;
  endfunction

  function automatic void model_step(logic r, logic v, int d, logic fs, logic cr, int cc);
    if (!r) begin
      m_clearing = 0; m_wr = 0; m_next_fill = 0;
      e_wea = 0; e_addr = 0; e_din = 0; e_fd = 0;
    end else if (!m_clearing) begin
      e_fd = 0; e_wea = 0;
      if (v) begin
        e_wea = 1; e_addr = m_wr; e_din = d; e_fd = (m_wr == DEPTH - 1) ? 1 : 0;
        m_wr = (m_wr + 1) % DEPTH;
      end
      if (fs) m_wr = 0;
      if (cr) begin m_clearing = 1; m_color = cc; m_next_fill = 0; end
    end else begin
      e_wea = 1; e_addr = m_next_fill; e_din = m_color;
      e_fd = (m_next_fill == DEPTH - 1) ? 1 : 0;
      if (m_next_fill == DEPTH - 1) begin m_clearing = 0; m_wr = 0; end
      else m_next_fill++;
    end
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic apply(logic r, logic v, int d, logic fs, logic cr, int cc);
    reset_n = r; px_valid = v; px_data = DW'(d);
    frame_start = fs; clear_req = cr; clear_color = DW'(cc);
    last_hs = r && v && (px_ready === 1'b1);
    @(posedge clk);
    model_step(r, v, d, fs, cr, cc);
    #1;
  endtask

  task automatic check_model();
    chk("wea", int'(bram_wea), e_wea);
    chk("addr", int'(bram_addr), e_addr);
    chk("din", int'(bram_din), e_din);
    chk("frame_done", int'(frame_done), e_fd);
    chk("clear_busy", int'(clear_busy), m_clearing ? 1 : 0);
    chk("px_ready", int'(px_ready), m_clearing ? 0 : 1);
  endtask

  task automatic step(logic r, logic v, int d, logic fs, logic cr, int cc);
    apply(r, v, d, fs, cr, cc);
    check_model();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_fill, cnt_busy, cnt_rdy_low, fd_addr;
    bit accepted;

    // Stream of 10 pixels wrapping the 8-pixel frame, then px_valid toggling.
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,1));
    for (int k = 1; k <= 10; k++)
      vecs.push_back(mk(1,1,k,0,0,0, 1,(k-1)%8,k,(k==8)?1:0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0, 0,1,'h00A,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,1));
    vecs.push_back(mk(1,1,'h111,0,0,0, 1,0,'h111,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,     0,0,'h111,0,0,1));
    vecs.push_back(mk(1,1,'h222,0,0,0, 1,1,'h222,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,     0,1,'h222,0,0,1));

    foreach (vecs[i]) begin
      apply(vecs[i].rst_n, vecs[i].v, vecs[i].d, vecs[i].fs, vecs[i].cr, vecs[i].cc);
      chk("tbl_wea", int'(bram_wea), vecs[i].ewea);
      chk("tbl_addr", int'(bram_addr), vecs[i].eaddr);
      chk("tbl_din", int'(bram_din), vecs[i].edin);
      chk("tbl_frame_done", int'(frame_done), vecs[i].efd);
      chk("tbl_clear_busy", int'(clear_busy), vecs[i].ebusy);
      chk("tbl_px_ready", int'(px_ready), vecs[i].erdy);
    end

    // frame_start together with the 4th pixel.
    step(0,0,0,0,0,0);
    step(1,1,'h101,0,0,0); step(1,1,'h102,0,0,0); step(1,1,'h103,0,0,0);
    step(1,1,'hABC,1,0,0);
    chk("fs_pixel_addr", int'(bram_addr), 3);
    chk("fs_pixel_din", int'(bram_din), 'hABC);
    step(1,1,'h104,0,0,0);
    chk("fs_next_addr", int'(bram_addr), 0);
    step(1,0,0,0,0,0);

    // clear_req together with a pixel at addr 2; source then holds a pixel.
    step(0,0,0,0,0,0);
    step(1,1,'h0A1,0,0,0); step(1,1,'h0A2,0,0,0);
    step(1,1,'h123,0,1,'hF00);
    chk("clr_pixel_addr", int'(bram_addr), 2);
    chk("clr_pixel_din", int'(bram_din), 'h123);
    cnt_fill = 0; cnt_busy = int'(clear_busy); cnt_rdy_low = int'(!px_ready); fd_addr = -1;
    accepted = 0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      step(1,1,'h456,0,0,0);
      accepted = last_hs;
      if (!accepted) begin
        if (bram_wea && bram_din == 12'hF00) cnt_fill++;
        if (clear_busy) cnt_busy++;
        if (!px_ready) cnt_rdy_low++;
        if (frame_done) fd_addr = int'(bram_addr);
      end
    end
    chk("clr_accepted", int'(accepted), 1);
    chk("clr_fill_writes", cnt_fill, 8);
    chk("clr_busy_cycles", cnt_busy, 8);
    chk("clr_ready_low_cycles", cnt_rdy_low, 8);
    chk("clr_done_addr", fd_addr, 7);
    chk("clr_resume_addr", int'(bram_addr), 0);
    chk("clr_resume_din", int'(bram_din), 'h456);
    step(1,0,0,0,0,0);

    // clear_req and frame_start pulsed in the 3rd cycle of a fill are ignored.
    step(0,0,0,0,0,0);
    step(1,0,0,0,1,'h0C0);
    cnt_fill = 0; fd_addr = -1;
    step(1,0,0,0,0,0); step(1,0,0,0,0,0);
    cnt_fill = 2;
    step(1,0,0,1,1,'hFFF);
    for (int i = 0; i < 5; i++) begin
      step(1,0,0,0,0,0);
      if (frame_done) fd_addr = int'(bram_addr);
      if (bram_wea && bram_din == 12'h0C0) cnt_fill++;
    end
    chk("ign_fill_writes", cnt_fill, 7);
    chk("ign_done_addr", fd_addr, 7);
    step(1,1,'h777,0,0,0);
    chk("ign_resume_addr", int'(bram_addr), 0);

    // Reset in the 4th cycle of a fill aborts it.
    step(0,0,0,0,0,0);
    step(1,0,0,0,1,'h0F0);
    step(1,0,0,0,0,0); step(1,0,0,0,0,0); step(1,0,0,0,0,0);
    step(0,0,0,0,0,0);
    chk("rst_abort_wea", int'(bram_wea), 0);
    chk("rst_abort_ready", int'(px_ready), 1);
    step(1,0,0,0,0,0);
    chk("rst_idle_wea", int'(bram_wea), 0);
    step(1,1,'h321,0,0,0);
    chk("rst_next_addr", int'(bram_addr), 0);
    chk("rst_next_din", int'(bram_din), 'h321);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), 1'($urandom), int'($urandom_range(0, 4095)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0),
           int'($urandom_range(0, 4095)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
